compare_engine: RTL and testbench

COMPARE_ENGINE -- requirements
Module: compare_engine

---
 rtl/compare_engine_if.sv | 24 ++
 rtl/compare_engine.sv | 140 ++++++++++++++
 tb/tb_compare_engine.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/compare_engine_if.sv
// compare_engine_if -- request/result bundle for the byte-serial compare engine.
// master drives the request (start, operands, condition select); slave returns
// status and results. Clock and reset are kept as plain ports on the engine.
interface compare_engine_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  funct3;
  logic        busy;
  logic        done;
  logic [31:0] diff;
  logic [31:0] result;
  logic        taken;

  modport master (
    output start, a, b, funct3,
    input  busy, done, diff, result, taken
  );

  modport slave (
    input  start, a, b, funct3,
    output busy, done, diff, result, taken
  );
endinterface

// File: rtl/compare_engine.sv
// compare_engine -- byte-serial subtract-and-compare unit.
// Computes diff = a - b one byte per cycle (LSB first, carry chained) and
// evaluates a branch-style condition selected by funct3.
// Optional feature: define UNSIGNED_CMP_EN to add the unsigned compares
// (funct3 110 -> a <u b, 111 -> a >=u b); without it those codes give 0.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation are held
// CALC  | four cycles, one diff byte per cycle, zero flag accumulating
// DONE  | one cycle, done pulse, results valid
module compare_engine (
  input  logic                clk,
  input  logic                rst_n,
  compare_engine_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  funct3_q;
  logic [1:0]  cnt_q;
  logic        carry_q;
  logic        z_q;
  logic [31:0] diff_q;
  logic        taken_q;
  logic        busy_q;
  logic        done_q;

  logic [7:0]  a_byte_d;
  logic [7:0]  b_byte_d;
  logic [8:0]  sum_d;
  logic        z_d;
  logic        n_d;
  logic        v_d;
`ifdef UNSIGNED_CMP_EN
  logic        c_d;
`endif
  logic        taken_d;

  // Byte-slice adder: current byte of a plus inverted byte of b plus chained carry.
  always_comb begin
    a_byte_d = a_q[{cnt_q, 3'b000} +: 8];
    b_byte_d = b_q[{cnt_q, 3'b000} +: 8];
    sum_d    = {1'b0, a_byte_d} + {1'b0, ~b_byte_d} + {8'b0, carry_q};
  end

  // Final flags as they stand after the current byte; only meaningful on byte 3.
  // N/V/C are folded straight into taken_q on that edge rather than kept around.
  always_comb begin
    z_d = z_q & (sum_d[7:0] == 8'h00);
    n_d = sum_d[7];
    v_d = (a_q[31] != b_q[31]) & (n_d != a_q[31]);
`ifdef UNSIGNED_CMP_EN
    c_d = sum_d[8];
`endif
  end

  // Condition select on the final flags.
  always_comb begin
    taken_d = 1'b0;
    case (funct3_q)
      3'b000:  taken_d = z_d;
      3'b001:  taken_d = ~z_d;
      3'b100:  taken_d = n_d ^ v_d;
      3'b101:  taken_d = ~(n_d ^ v_d);
`ifdef UNSIGNED_CMP_EN
      3'b110:  taken_d = ~c_d;
      3'b111:  taken_d = c_d;
`endif
      default: taken_d = 1'b0;
    endcase
  end

  // Sequencer: capture on start, four byte steps, one-cycle done, back to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      funct3_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      z_q      <= 1'b0;
      diff_q   <= '0;
      taken_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            funct3_q <= bus.funct3;
            cnt_q    <= 2'd0;
            carry_q  <= 1'b1;
            z_q      <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          diff_q[{cnt_q, 3'b000} +: 8] <= sum_d[7:0];
          carry_q <= sum_d[8];
          z_q     <= z_d;
          cnt_q   <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            taken_q <= taken_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.taken  = taken_q;
  assign bus.result = {31'b0, taken_q};

endmodule

// File: tb/tb_compare_engine.sv
// tb_compare_engine -- scoreboard bench for compare_engine.
// A cycle-level reference tracks acceptance and pushes expected results; the
// negedge monitor pops them on the done cycle and also checks busy/done timing
// and result hold between operations.
module tb_compare_engine;

  logic clk;
  logic rst_n;
  compare_engine_if bus ();

  compare_engine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] diff;
    logic        taken;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   mcnt = 0;
  int   done_cnt = 0;
  exp_t last_e;
  bit   last_valid = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    exp_t e;
    e.diff = a - b;
    case (f)
      3'b000:  e.taken = (a == b);
      3'b001:  e.taken = (a != b);
      3'b100:  e.taken = ($signed(a) <  $signed(b));
      3'b101:  e.taken = ($signed(a) >= $signed(b));
`ifdef UNSIGNED_CMP_EN
      3'b110:  e.taken = (a <  b);
      3'b111:  e.taken = (a >= b);
`endif
      default: e.taken = 1'b0;
    endcase
    return e;
  endfunction

  // Reference sequencer: accept in idle, then 4 CALC + 1 DONE cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= 0;
      sb.delete();
    end else if (mcnt == 0) begin
      if (bus.start) begin
        sb.push_back(model(bus.a, bus.b, bus.funct3));
        mcnt <= 5;
      end
    end else begin
      mcnt <= mcnt - 1;
    end
  end

  // Monitor: timing of busy/done, scoreboard compare on done, hold while idle.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_valid = 0;
    end else begin
      chk("busy", {31'b0, bus.busy}, {31'b0, (mcnt != 0)});
      chk("done", {31'b0, bus.done}, {31'b0, (mcnt == 1)});
      if (bus.done) done_cnt++;
      if (mcnt == 1) begin
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
          last_e = sb.pop_front();
          last_valid = 1;
          chk("diff",   bus.diff,   last_e.diff);
          chk("taken",  {31'b0, bus.taken}, {31'b0, last_e.taken});
          chk("result", bus.result, {31'b0, last_e.taken});
        end
      end else if (mcnt == 0 && last_valid) begin
        chk("hold_diff",   bus.diff,   last_e.diff);
        chk("hold_result", bus.result, {31'b0, last_e.taken});
      end
    end
  end

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mcnt == 0 && sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk("idle_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.a      = a;
    bus.b      = b;
    bus.funct3 = f;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.a      = ~a;
    bus.b      = ~b;
    bus.funct3 = ~f;
    wait_idle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   {31'b0, bus.busy},  32'd0);
    chk({tag, "_done"},   {31'b0, bus.done},  32'd0);
    chk({tag, "_taken"},  {31'b0, bus.taken}, 32'd0);
    chk({tag, "_diff"},   bus.diff,           32'd0);
    chk({tag, "_result"}, bus.result,         32'd0);
  endtask

  initial begin
    int snap;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    bus.funct3 = '0;
    #17;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_op(32'd5,        32'd5,        3'b000);
    do_op(32'h80000000, 32'd1,        3'b100);
    do_op(32'hFFFFFFFF, 32'd1,        3'b110);
    do_op(32'hFFFFFFFF, 32'd1,        3'b111);
    do_op(32'hFFFFFFFF, 32'd1,        3'b100);
    do_op(32'h00000100, 32'd1,        3'b001);
    do_op(32'h7FFFFFFF, 32'hFFFFFFFF, 3'b101);
    do_op(32'd1,        32'd2,        3'b110);
    do_op(32'd3,        32'd3,        3'b001);
    do_op(32'd9,        32'd4,        3'b010);
    do_op(32'h12345678, 32'h12345678, 3'b011);

    // Random cases, some with equal operands
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? ra : $urandom;
      do_op(ra, rb, 3'($urandom_range(0, 7)));
    end

    // Abort in the second CALC cycle
    @(negedge clk);
    bus.start  = 1'b1;
    bus.a      = 32'h12345678;
    bus.b      = 32'd1;
    bus.funct3 = 3'b000;
    @(negedge clk);
    bus.start  = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("abort");
    snap = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done", done_cnt, snap);
    do_op(32'h00000100, 32'h00000001, 3'b001);

    // Start held high for 12 cycles, operands changed mid-CALC
    snap = done_cnt;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.a      = 32'd10;
    bus.b      = 32'd20;
    bus.funct3 = 3'b100;
    repeat (2) @(negedge clk);
    bus.a      = 32'd20;
    bus.b      = 32'd20;
    bus.funct3 = 3'b000;
    repeat (10) @(negedge clk);
    bus.start  = 1'b0;
    wait_idle();
    chk("b2b_done_count", done_cnt - snap, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
